// File: rtl/rv32i_ctrl_pkg.sv
// Shared RV32I control types: memory access widths, LSU state encoding,
// and the funct3 legality / alignment rules used when an access is accepted.
// Pure declarations; no logic of its own.
package rv32i_ctrl;

   // funct3 encodings of the RV32I load/store width field
   typedef enum logic [2:0] {
      mem_b  = 3'b000,
      mem_h  = 3'b001,
      mem_w  = 3'b010,
      mem_bu = 3'b100,
      mem_hu = 3'b101
   } mem_width_e;

   typedef enum logic [2:0] {
      LSU_IDLE   = 3'd0,
      LSU_REQ    = 3'd1,
      LSU_WAIT_R = 3'd2,
      LSU_DONE   = 3'd3,
      LSU_EXC    = 3'd4
   } lsu_state_t;

   // Stores only have signed-less widths; BU/HU exist for loads only.
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         mem_b, mem_h, mem_w: ok = 1'b1;
         mem_bu, mem_hu:      ok = !we;
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Only meaningful for legal funct3; low two bits encode the access size.
   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (f3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables / replicated data, load extract/extend.
// Latency: purely combinational.
// No handshake; outputs follow inputs.
module lsu_align
   import rv32i_ctrl::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store lanes: replicate data so any byte enable finds its value in place.
   // Loads always fetch the full word.
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      if (we_i) begin
         case (funct3_i[1:0])
            2'b00: begin
               be_o    = 4'b0001 << off_i;
               wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
               be_o    = off_i[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
               be_o    = 4'b1111;
               wdata_o = wdata_i;
            end
         endcase
      end
   end

   // Load data: pick the addressed byte/halfword and extend to 32 bits.
   always_comb begin
      byte_sel = rdata_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         mem_b:   ldata_o = {{24{byte_sel[7]}}, byte_sel};
         mem_bu:  ldata_o = {24'h000000, byte_sel};
         mem_h:   ldata_o = {{16{half_sel[15]}}, half_sel};
         mem_hu:  ldata_o = {16'h0000, half_sel};
         default: ldata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding request/grant/rvalid access at a time.
// Latency: load response 3 cycles after accept, store 2, exceptions 1 (minimum).
// Backpressure: req_ready only in IDLE; mem_req held until mem_gnt or timeout.
module lsu
   import rv32i_ctrl::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TCNT_W  = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [4:0]  rsp_rd,
   output logic        exc_misalign,
   output logic        exc_illegal,
   output logic        exc_bus
);

   lsu_state_t        state_q, state_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       addr_q, wdata_q;
   logic              we_q, ill_q, mis_q;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q;

   logic              acc_ill, acc_mis, timed_out;
   logic [31:0]       ldata;

   // Illegal takes precedence, so misalign is suppressed when both apply.
   assign acc_ill   = !funct3_legal(req_we, req_funct3);
   assign acc_mis   = addr_misaligned(req_funct3, req_addr[1:0]) && !acc_ill;
   assign timed_out = (TIMEOUT != 0) &&
                      ((state_q == LSU_REQ) || (state_q == LSU_WAIT_R)) &&
                      (tcnt_q == TCNT_W'(TIMEOUT));

   lsu_align u_align (
      .we_i     (we_q),
      .funct3_i (f3_q),
      .off_i    (addr_q[1:0]),
      .wdata_i  (wdata_q),
      .rdata_i  (mem_rdata),
      .be_o     (mem_be),
      .wdata_o  (mem_wdata),
      .ldata_o  (ldata)
   );

   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_we    = we_q;
   assign rsp_rdata = (state_q == LSU_DONE) ? rdata_q : 32'h0;
   assign rsp_rd    = (state_q == LSU_DONE) ? rd_q    : 5'd0;

   // FSM state, timeout counter and captured load data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LSU_IDLE;
         tcnt_q  <= '0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Request attributes latched at accept, held stable for the memory port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         rd_q    <= 5'd0;
         ill_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else if (req_valid && (state_q == LSU_IDLE)) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         we_q    <= req_we;
         f3_q    <= req_funct3;
         rd_q    <= req_rd;
         ill_q   <= acc_ill;
         mis_q   <= acc_mis;
      end
   end

   // Next state and all handshake/pulse outputs; outputs decode from state so reset clears them at once.
   always_comb begin
      state_d      = state_q;
      tcnt_d       = tcnt_q;
      rdata_d      = rdata_q;
      req_ready    = 1'b0;
      mem_req      = 1'b0;
      rsp_valid    = 1'b0;
      exc_misalign = 1'b0;
      exc_illegal  = 1'b0;
      exc_bus      = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               rdata_d = 32'h0;
               if (acc_ill || acc_mis) begin
                  state_d = LSU_EXC;
               end else begin
                  state_d = LSU_REQ;
                  tcnt_d  = '0;
               end
            end
         end
         LSU_REQ: begin
            tcnt_d = tcnt_q + 1'b1;
            if (timed_out) begin
               exc_bus = 1'b1;
               state_d = LSU_IDLE;
            end else begin
               mem_req = 1'b1;
               if (mem_gnt) begin
                  state_d = we_q ? LSU_DONE : LSU_WAIT_R;
               end
            end
         end
         LSU_WAIT_R: begin
            tcnt_d = tcnt_q + 1'b1;
            if (timed_out) begin
               exc_bus = 1'b1;
               state_d = LSU_IDLE;
            end else if (mem_rvalid) begin
               rdata_d = ldata;
               state_d = LSU_DONE;
            end
         end
         LSU_DONE: begin
            rsp_valid = 1'b1;
            state_d   = LSU_IDLE;
         end
         LSU_EXC: begin
            exc_illegal  = ill_q;
            exc_misalign = mis_q;
            state_d      = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT=4: loads, stores, exceptions, timeout, reset.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Every check goes through check_eq.
module tb_lsu;

   logic        clk, rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [4:0]  rsp_rd;
   logic        exc_misalign, exc_illegal, exc_bus;

   int n_vec = 0;
   int n_err = 0;

   lsu #(.TIMEOUT(4), .TCNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
      .exc_misalign(exc_misalign), .exc_illegal(exc_illegal), .exc_bus(exc_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [4:0] rd, input logic [31:0] exp_addr, input logic [31:0] exp);
      cyc(); req_valid = 1; req_we = 0; req_funct3 = f3; req_addr = addr; req_rd = rd;
      smp(); check_eq("ld_ready", req_ready, 1);
      cyc(); req_valid = 0; mem_gnt = 1;
      smp(); check_eq("ld_mem_req", mem_req, 1); check_eq("ld_be", mem_be, 4'b1111);
      check_eq("ld_addr", mem_addr, exp_addr); check_eq("ld_we", mem_we, 0);
      cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = rdata;
      smp(); check_eq("ld_rsp_early", rsp_valid, 0); check_eq("ld_req_drop", mem_req, 0);
      cyc(); mem_rvalid = 0; mem_rdata = 32'h0;
      smp(); check_eq("ld_rsp_valid", rsp_valid, 1); check_eq("ld_rdata", rsp_rdata, exp);
      check_eq("ld_rd", rsp_rd, rd);
      cyc();
      smp(); check_eq("ld_rsp_pulse", rsp_valid, 0); check_eq("ld_ready_back", req_ready, 1);
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      cyc(); req_valid = 1; req_we = 1; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
      smp(); check_eq("st_ready", req_ready, 1);
      cyc(); req_valid = 0; mem_gnt = 1;
      smp(); check_eq("st_mem_req", mem_req, 1); check_eq("st_we", mem_we, 1);
      check_eq("st_be", mem_be, exp_be); check_eq("st_wdata", mem_wdata, exp_wd);
      cyc(); mem_gnt = 0;
      smp(); check_eq("st_rsp_valid", rsp_valid, 1); check_eq("st_rdata", rsp_rdata, 0);
      check_eq("st_rd", rsp_rd, rd);
      cyc();
      smp(); check_eq("st_rsp_pulse", rsp_valid, 0);
   endtask

   task automatic do_exc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic exp_ill, input logic exp_mis);
      cyc(); req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_rd = 5'd1;
      smp(); check_eq("ex_ready", req_ready, 1);
      cyc(); req_valid = 0;
      smp(); check_eq("ex_illegal", exc_illegal, exp_ill); check_eq("ex_misalign", exc_misalign, exp_mis);
      check_eq("ex_no_req", mem_req, 0); check_eq("ex_no_rsp", rsp_valid, 0);
      check_eq("ex_busy", req_ready, 0);
      cyc();
      smp(); check_eq("ex_pulse_ill", exc_illegal, 0); check_eq("ex_pulse_mis", exc_misalign, 0);
      check_eq("ex_no_req2", mem_req, 0); check_eq("ex_ready_back", req_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int req_cycles;
      rst = 1; req_valid = 0; req_we = 0; req_funct3 = 3'b000; req_addr = 32'h0;
      req_wdata = 32'h0; req_rd = 5'd0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;

      // reset state
      smp();
      check_eq("rst_ready", req_ready, 1); check_eq("rst_mem_req", mem_req, 0);
      check_eq("rst_rsp", rsp_valid, 0); check_eq("rst_exc_bus", exc_bus, 0);
      cyc(); rst = 0;

      // LB at 0x1003, byte 0x80 sign-extends
      do_load(3'b000, 32'h0000_1003, 32'h80AA_BBCC, 5'd5, 32'h0000_1000, 32'hFFFF_FF80);
      do_load(3'b000, 32'h0000_1001, 32'h80AA_BB7C, 5'd6, 32'h0000_1000, 32'hFFFF_FFBB);
      do_load(3'b001, 32'h0000_6002, 32'h8001_7FFF, 5'd7, 32'h0000_6000, 32'hFFFF_8001);
      do_load(3'b101, 32'h0000_6000, 32'h8001_F00D, 5'd8, 32'h0000_6000, 32'h0000_F00D);
      do_load(3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 5'd9, 32'h0000_7000, 32'hDEAD_BEEF);

      // store lanes with immediate grant
      do_store(3'b000, 32'h0000_5001, 32'h0000_00A5, 5'd10, 4'b0010, 32'hA5A5_A5A5);
      do_store(3'b001, 32'h0000_5000, 32'h1234_5678, 5'd11, 4'b0011, 32'h5678_5678);
      do_store(3'b010, 32'h0000_5004, 32'hCAFE_F00D, 5'd12, 4'b1111, 32'hCAFE_F00D);

      // SH at 0x2002 with three stall cycles before grant
      cyc(); req_valid = 1; req_we = 1; req_funct3 = 3'b001; req_addr = 32'h0000_2002;
      req_wdata = 32'h1234_ABCD; req_rd = 5'd13;
      cyc(); req_valid = 0;
      req_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         mem_gnt = (i == 3);
         smp();
         if (mem_req) req_cycles++;
         check_eq("sh_be", mem_be, 4'b1100); check_eq("sh_wdata", mem_wdata, 32'hABCD_ABCD);
         check_eq("sh_no_rsp", rsp_valid, 0);
         cyc();
      end
      mem_gnt = 0;
      check_eq("sh_req_cycles", req_cycles, 4);
      smp(); check_eq("sh_rsp_valid", rsp_valid, 1); check_eq("sh_rdata", rsp_rdata, 0);
      check_eq("sh_rd", rsp_rd, 13); check_eq("sh_req_off", mem_req, 0);
      cyc();
      smp(); check_eq("sh_rsp_pulse", rsp_valid, 0);

      // exceptions
      do_exc(1'b0, 3'b010, 32'h0000_3001, 1'b0, 1'b1);   // LW misaligned
      do_exc(1'b0, 3'b011, 32'h0000_3001, 1'b1, 1'b0);   // reserved funct3, illegal wins
      do_exc(1'b1, 3'b100, 32'h0000_3000, 1'b1, 1'b0);   // SBU is not a store
      do_exc(1'b1, 3'b001, 32'h0000_3003, 1'b0, 1'b1);   // SH misaligned

      // LHU timeout: grant but no read data; rvalid during REQ is ignored
      cyc(); req_valid = 1; req_we = 0; req_funct3 = 3'b101; req_addr = 32'h0000_0010; req_rd = 5'd4;
      cyc(); req_valid = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      smp(); check_eq("to_req", mem_req, 1); check_eq("to_bus_c1", exc_bus, 0);
      for (int c = 2; c <= 4; c++) begin
         cyc(); mem_gnt = 0; mem_rvalid = 0;
         smp(); check_eq("to_bus_early", exc_bus, 0); check_eq("to_no_rsp", rsp_valid, 0);
      end
      cyc();
      smp(); check_eq("to_bus", exc_bus, 1); check_eq("to_req_drop", mem_req, 0);
      check_eq("to_rsp_none", rsp_valid, 0);
      cyc(); mem_rvalid = 1;
      smp(); check_eq("to_bus_pulse", exc_bus, 0); check_eq("to_late_rsp", rsp_valid, 0);
      check_eq("to_ready", req_ready, 1);
      cyc(); mem_rvalid = 0;
      smp(); check_eq("to_late_rsp2", rsp_valid, 0);

      // async reset while in WAIT_R
      cyc(); req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h0000_0040; req_rd = 5'd9;
      cyc(); req_valid = 0; mem_gnt = 1;
      smp(); check_eq("rw_req", mem_req, 1);
      cyc(); mem_gnt = 0;
      #1 rst = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
      #1 check_eq("rw_ready", req_ready, 1); check_eq("rw_mem_req", mem_req, 0);
      check_eq("rw_rsp", rsp_valid, 0);
      cyc(); mem_rvalid = 0;
      smp(); check_eq("rw_rsp2", rsp_valid, 0);
      cyc(); rst = 0;

      // async reset while mem_req is high in REQ
      cyc(); req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h0000_0080; req_rd = 5'd2;
      cyc(); req_valid = 0;
      #1 check_eq("rr_req_before", mem_req, 1);
      rst = 1;
      #1 check_eq("rr_req_drop", mem_req, 0); check_eq("rr_ready", req_ready, 1);
      cyc(); rst = 0;
      smp(); check_eq("rr_no_rsp", rsp_valid, 0);

      // recovery: LBU at 0x0
      do_load(3'b100, 32'h0000_0000, 32'h0000_00F0, 5'd3, 32'h0000_0000, 32'h0000_00F0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU in the RV32I core.
- Takes the ALU sum as the effective address, plus rs2 data and funct3.
- Drives a single-outstanding request/grant/rvalid data-memory port with byte enables.
- Returns aligned, sign- or zero-extended load data and rd tag to writeback; flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 64, cycles allowed in REQ+WAIT_R before bus error; 0 disables timeout
TCNT_W, 8, width of timeout counter; must satisfy 2^TCNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign field (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  effective address (ALU out)
req_wdata  in  32  store data (rs2)
req_rd  in  5  destination register tag
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  memory write enable
mem_addr  out  32  word address, {req_addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  raw read word
rsp_valid  out  1  one-cycle completion pulse (load or store)
rsp_rdata  out  32  extended load data; 0 for stores
rsp_rd  out  5  tag of completed op
exc_misalign  out  1  one-cycle pulse, misaligned access
exc_illegal  out  1  one-cycle pulse, reserved funct3
exc_bus  out  1  one-cycle pulse, timeout

Behaviour:
- Reset: state=IDLE; all registered outputs 0; timeout counter 0. req_ready=1 once state is IDLE. An in-flight access is abandoned and mem_req drops immediately, asynchronously.
- FSM states: IDLE, REQ, WAIT_R, DONE, EXC.
- IDLE:
  - On req_valid&&req_ready, latch addr/we/funct3/wdata/rd.
  - Legal and aligned: go to REQ.
  - Otherwise: go to EXC. No mem_req is ever issued for such an access.
- Legality:
  - Loads: funct3 in {000,001,010,100,101}.
  - Stores: funct3 in {000,001,010}.
  - Any other value raises exc_illegal.
- Alignment:
  - Halfword needs addr[0]=0; word needs addr[1:0]=0. Otherwise exc_misalign.
  - If an access is both illegal and misaligned, only illegal is reported.
- EXC: exactly one exception pulse this cycle, rsp_valid=0, then IDLE.
- REQ:
  - mem_req=1; mem_addr/mem_we/mem_be/mem_wdata stable until gnt.
  - On gnt, a store goes to DONE and a load goes to WAIT_R.
- WAIT_R:
  - Capture extended mem_rdata on mem_rvalid, then go to DONE.
  - mem_rvalid is honoured only in WAIT_R; it arrives at earliest one cycle after gnt. rvalid seen in IDLE or REQ is ignored.
- DONE: rsp_valid=1 for one cycle with rsp_rd and rsp_rdata, then IDLE. A new request is accepted the following cycle (no back-to-back in DONE).
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT_R.
  - When it equals TIMEOUT (if TIMEOUT≠0): exc_bus pulse, mem_req drops, go to IDLE, and the op is discarded.
- Store lanes, with o=addr[1:0]:
  - SB: be=4'b0001<<o; wdata = byte replicated x4.
  - SH: be=0011 (o=0) or 1100 (o=2); wdata = halfword replicated x2.
  - SW: be=1111.
- Loads: be=1111 for every load. Extract the byte at o*8 or the halfword at o[1]*16. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Minimum latency:
  - Load: accept@0, REQ+gnt@1, rvalid@2, rsp_valid@3.
  - Store: rsp_valid@2.

Decomposition:
- Shared package rv32i_ctrl gains:
  - mem_width enum: mem_b=3'b000, mem_h=3'b001, mem_w=3'b010, mem_bu=3'b100, mem_hu=3'b101.
  - lsu_state_t enum.
- One sub-module, lsu_align (combinational): load extract/extend and store be/wdata generation, tested standalone.

Test Plan:
- LB at 0x1003, mem_rdata=0x80AA_BBCC -> rsp_rdata=0xFFFF_FF80, rsp_valid at cycle 3, mem_be=1111, mem_addr=0x1000.
- SH at 0x2002, wdata=0x1234_ABCD, gnt after 3 stall cycles -> mem_req held 4 cycles, mem_be=1100, mem_wdata=0xABCD_ABCD, then one rsp_valid pulse with rsp_rdata=0.
- LW at 0x3001 -> exc_misalign one pulse, mem_req never asserted, req_ready back to 1 two cycles after accept.
- Load with funct3=3'b011 at 0x3001 -> exc_illegal only (no misalign), no mem_req.
- TIMEOUT=4, LHU with gnt but no rvalid -> exc_bus on the 4th cycle after REQ entry; a late rvalid=1 afterwards produces no rsp_valid.
- rst asserted during WAIT_R -> mem_req/rsp_valid 0 immediately, state IDLE; next LBU at 0x0 with rdata 0x0000_00F0 -> rsp_rdata=0x0000_00F0.
